// File: rtl/p2p_cfg_router.sv
// Packet-aware N-window address router for the P2P configuration request stream.
// Unmatched packets are drained at line rate and logged.
module p2p_cfg_router #(
    parameter int                     CHNL_NUM = 4,
    parameter int                     HEAD_W   = 128,
    parameter int                     DATA_W   = 256,
    parameter int                     ADDR_LSB = 32,
    parameter logic [CHNL_NUM*32-1:0] BASE_VEC = '0,
    parameter logic [CHNL_NUM*32-1:0] MASK_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic                       s_last,
    input  logic [HEAD_W-1:0]          s_head,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic [CHNL_NUM-1:0]        m_valid,
    output logic [CHNL_NUM-1:0]        m_last,
    output logic [CHNL_NUM*HEAD_W-1:0] m_head,
    output logic [CHNL_NUM*DATA_W-1:0] m_data,
    input  logic [CHNL_NUM-1:0]        m_ready,
    output logic                       busy,
    output logic                       err_valid,
    output logic [31:0]                err_addr,
    output logic [15:0]                drop_cnt
);

    localparam int SEL_W = (CHNL_NUM > 1) ? $clog2(CHNL_NUM) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t              state;
    logic                stg_vld;
    logic                stg_last;
    logic [HEAD_W-1:0]   stg_head;
    logic [DATA_W-1:0]   stg_data;
    logic [HEAD_W-1:0]   hold_head;
    logic [SEL_W-1:0]    sel;
    logic [31:0]         err_addr_q;

    logic [31:0]         addr;
    logic [CHNL_NUM-1:0] hit;
    logic                hit_any;
    logic [SEL_W-1:0]    hit_idx;
    logic [SEL_W-1:0]    route;
    logic [HEAD_W-1:0]   out_head;
    logic                fwd_act;
    logic                drop_act;
    logic                stg_pop;

    assign addr = stg_head[ADDR_LSB +: 32];

    always_comb begin
        hit = '0;
        for (int i = 0; i < CHNL_NUM; i++) begin
            hit[i] = ((addr & MASK_VEC[32*i +: 32]) ==
                      (BASE_VEC[32*i +: 32] & MASK_VEC[32*i +: 32]));
        end
    end

    // Descending scan so the lowest matching index is written last and wins.
    always_comb begin
        hit_idx = '0;
        for (int i = CHNL_NUM - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = SEL_W'(i);
        end
    end

    assign hit_any  = |hit;
    assign route    = (state == IDLE) ? hit_idx : sel;
    assign out_head = (state == IDLE) ? stg_head : hold_head;

    assign fwd_act  = stg_vld && ((state == IDLE && hit_any) || state == FWD);
    assign drop_act = stg_vld && ((state == IDLE && !hit_any) || state == DROP);
    assign stg_pop  = drop_act || (fwd_act && m_ready[route]);
    assign s_ready  = !rst && (!stg_vld || stg_pop);

    assign busy      = (state != IDLE);
    assign err_valid = stg_vld && (state == IDLE) && !hit_any;
    assign err_addr  = err_valid ? addr : err_addr_q;

    always_comb begin
        m_valid = '0;
        m_last  = '0;
        m_head  = '0;
        m_data  = '0;
        for (int i = 0; i < CHNL_NUM; i++) begin
            if (fwd_act && route == SEL_W'(i)) begin
                m_valid[i]                  = 1'b1;
                m_last[i]                   = stg_last;
                m_head[i*HEAD_W +: HEAD_W]  = out_head;
                m_data[i*DATA_W +: DATA_W]  = stg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stg_vld    <= 1'b0;
            stg_last   <= 1'b0;
            stg_head   <= '0;
            stg_data   <= '0;
            hold_head  <= '0;
            sel        <= '0;
            err_addr_q <= '0;
            drop_cnt   <= '0;
        end else begin
            if (s_valid && s_ready) begin
                stg_vld  <= 1'b1;
                stg_last <= s_last;
                stg_head <= s_head;
                stg_data <= s_data;
            end else if (stg_pop) begin
                stg_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (stg_vld && hit_any) begin
                        sel       <= hit_idx;
                        hold_head <= stg_head;
                        if (stg_pop && !stg_last) state <= FWD;
                    end else if (stg_vld) begin
                        err_addr_q <= addr;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        if (!stg_last) state <= DROP;
                    end
                end
                FWD, DROP: begin
                    if (stg_pop && stg_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p2p_cfg_router.sv
// Directed bench for p2p_cfg_router: routing, drop, back-pressure, overlap,
// mid-packet reset and drop counter saturation.
module tb_p2p_cfg_router;

    localparam int N  = 4;
    localparam int HW = 128;
    localparam int DW = 256;

    localparam logic [N*32-1:0] BASES =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASKS  = {4{32'hF000_0000}};
    localparam logic [N*32-1:0] MASKS2 =
        {32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_last;
    logic [HW-1:0]   s_head;
    logic [DW-1:0]   s_data;
    logic [N-1:0]    m_ready;

    logic            s_ready;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_last;
    logic [N*HW-1:0] m_head;
    logic [N*DW-1:0] m_data;
    logic            busy;
    logic            err_valid;
    logic [31:0]     err_addr;
    logic [15:0]     drop_cnt;

    logic            s_ready2;
    logic [N-1:0]    m_valid2;
    logic [N-1:0]    m_last2;
    logic [N*HW-1:0] m_head2;
    logic [N*DW-1:0] m_data2;
    logic            busy2;
    logic            err_valid2;
    logic [31:0]     err_addr2;
    logic [15:0]     drop_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    p2p_cfg_router #(
        .CHNL_NUM(N), .HEAD_W(HW), .DATA_W(DW), .ADDR_LSB(32),
        .BASE_VEC(BASES), .MASK_VEC(MASKS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_last(s_last), .s_head(s_head),
        .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_last(m_last), .m_head(m_head),
        .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .err_valid(err_valid),
        .err_addr(err_addr), .drop_cnt(drop_cnt)
    );

    p2p_cfg_router #(
        .CHNL_NUM(N), .HEAD_W(HW), .DATA_W(DW), .ADDR_LSB(32),
        .BASE_VEC(BASES), .MASK_VEC(MASKS2)
    ) dut2 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_last(s_last), .s_head(s_head),
        .s_data(s_data), .s_ready(s_ready2),
        .m_valid(m_valid2), .m_last(m_last2), .m_head(m_head2),
        .m_data(m_data2), .m_ready(m_ready),
        .busy(busy2), .err_valid(err_valid2),
        .err_addr(err_addr2), .drop_cnt(drop_cnt2)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [HW-1:0] mk_head(input logic [31:0] a,
                                              input logic [31:0] tag);
        return {tag, 32'h0, a, 32'h5A5A_5A5A};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l,
                         input logic [HW-1:0] h, input logic [DW-1:0] d);
        s_valid = v;
        s_last  = l;
        s_head  = h;
        s_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int pulses;

    initial begin
        rst     = 1'b1;
        m_ready = '1;
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check("rst_s_ready", 256'(s_ready), 256'(0));
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_head", 256'(m_head[HW-1:0]), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err", 256'({err_valid, err_addr}), 256'(0));
        check("rst_drop_cnt", 256'(drop_cnt), 256'(0));
        rst = 1'b0;
        tick();
        check("idle_s_ready", 256'(s_ready), 256'(1));

        // 3-beat packet to channel 2
        drive(1'b1, 1'b0, mk_head(32'h2000_0040, 32'h1), 256'hD0);
        tick();
        check("p3_b1_valid", 256'(m_valid), 256'(4'b0100));
        check("p3_b1_head", 256'(m_head[2*HW +: HW]),
              256'(mk_head(32'h2000_0040, 32'h1)));
        check("p3_b1_data", m_data[2*DW +: DW], 256'hD0);
        check("p3_b1_last", 256'(m_last), 256'(0));
        drive(1'b1, 1'b0, mk_head(32'hFFFF_FFFF, 32'h2), 256'hD1);
        tick();
        check("p3_b2_valid", 256'(m_valid), 256'(4'b0100));
        check("p3_b2_head", 256'(m_head[2*HW +: HW]),
              256'(mk_head(32'h2000_0040, 32'h1)));
        check("p3_b2_data", m_data[2*DW +: DW], 256'hD1);
        check("p3_b2_busy", 256'(busy), 256'(1));
        drive(1'b1, 1'b1, mk_head(32'h5000_0000, 32'h3), 256'hD2);
        tick();
        check("p3_b3_valid", 256'(m_valid), 256'(4'b0100));
        check("p3_b3_head", 256'(m_head[2*HW +: HW]),
              256'(mk_head(32'h2000_0040, 32'h1)));
        check("p3_b3_last", 256'(m_last), 256'(4'b0100));
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("p3_done_valid", 256'(m_valid), 256'(0));
        check("p3_done_busy", 256'(busy), 256'(0));
        check("p3_no_err", 256'(drop_cnt), 256'(0));

        // 4-beat unmatched packet
        drive(1'b1, 1'b0, mk_head(32'h5000_0000, 32'h4), 256'hE0);
        tick();
        check("drop_b1_err", 256'(err_valid), 256'(1));
        check("drop_b1_addr", 256'(err_addr), 256'(32'h5000_0000));
        check("drop_b1_valid", 256'(m_valid), 256'(0));
        check("drop_b1_ready", 256'(s_ready), 256'(1));
        for (int b = 2; b <= 4; b++) begin
            drive(1'b1, b == 4, mk_head(32'h0, 32'h4), 256'(b));
            tick();
            check("drop_err_quiet", 256'(err_valid), 256'(0));
            check("drop_valid", 256'(m_valid), 256'(0));
            check("drop_ready", 256'(s_ready), 256'(1));
            check("drop_cnt1", 256'(drop_cnt), 256'(1));
        end
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("drop_end_busy", 256'(busy), 256'(0));
        check("drop_end_cnt", 256'(drop_cnt), 256'(1));
        check("drop_end_addr", 256'(err_addr), 256'(32'h5000_0000));

        // back-pressure on channel 0 with a channel 3 packet queued
        m_ready = 4'b1110;
        drive(1'b1, 1'b1, mk_head(32'h0000_0000, 32'h10), 256'hA0);
        tick();
        drive(1'b1, 1'b1, mk_head(32'h3000_0000, 32'h11), 256'hA1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 256'(m_valid), 256'(4'b0001));
            check("bp_data", m_data[0 +: DW], 256'hA0);
            check("bp_s_ready", 256'(s_ready), 256'(0));
            if (i < 4) tick();
        end
        m_ready = 4'b1111;
        tick();
        check("bp_ch3_valid", 256'(m_valid), 256'(4'b1000));
        check("bp_ch3_data", m_data[3*DW +: DW], 256'hA1);
        check("bp_ch3_head", 256'(m_head[3*HW +: HW]),
              256'(mk_head(32'h3000_0000, 32'h11)));
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("bp_done", 256'(m_valid), 256'(0));

        // overlapping windows on the second instance
        do_reset();
        drive(1'b1, 1'b1, mk_head(32'h1000_0000, 32'h20), 256'hB0);
        tick();
        check("ovl_low_wins", 256'(m_valid2), 256'(4'b0010));
        drive(1'b1, 1'b1, mk_head(32'h7000_0000, 32'h21), 256'hB1);
        tick();
        check("ovl_default", 256'(m_valid2), 256'(4'b1000));
        check("ovl_default_err", 256'(err_valid2), 256'(0));
        check("ovl_ref_err", 256'(err_valid), 256'(1));
        drive(1'b0, 1'b0, '0, '0);
        tick();
        check("ovl_cnt", 256'(drop_cnt2), 256'(0));
        check("ovl_ref_cnt", 256'(drop_cnt), 256'(1));

        // reset during beat 2 of a 4-beat packet
        drive(1'b1, 1'b0, mk_head(32'h2000_0000, 32'h30), 256'hC0);
        tick();
        check("mr_b1", 256'(m_valid), 256'(4'b0100));
        drive(1'b1, 1'b0, mk_head(32'h0, 32'h31), 256'hC1);
        rst = 1'b1;
        tick();
        check("mr_valid", 256'(m_valid), 256'(0));
        check("mr_busy", 256'(busy), 256'(0));
        check("mr_s_ready", 256'(s_ready), 256'(0));
        check("mr_cnt", 256'(drop_cnt), 256'(0));
        rst = 1'b0;
        drive(1'b1, 1'b1, mk_head(32'h1000_0000, 32'h32), 256'hC2);
        tick();
        check("mr_head_valid", 256'(m_valid), 256'(4'b0010));
        check("mr_head", 256'(m_head[1*HW +: HW]),
              256'(mk_head(32'h1000_0000, 32'h32)));
        check("mr_busy2", 256'(busy), 256'(0));
        drive(1'b0, 1'b0, '0, '0);
        tick();

        // drop counter saturation
        pulses = 0;
        drive(1'b1, 1'b1, mk_head(32'h5000_0000, 32'h40), 256'hF0);
        for (int k = 1; k <= 65540; k++) begin
            tick();
            if (err_valid) pulses++;
            if (k == 65535) check("sat_fffe", 256'(drop_cnt), 256'(16'hFFFE));
            if (k == 65536) check("sat_ffff", 256'(drop_cnt), 256'(16'hFFFF));
            if (k == 65540) s_valid = 1'b0;
        end
        tick();
        check("sat_final", 256'(drop_cnt), 256'(16'hFFFF));
        check("sat_pulses", 256'(pulses), 256'(65540));
        check("sat_quiet", 256'(err_valid), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/p2p_cfg_router.md
# p2p_cfg_router

Parametrised, packet-aware address router for the P2P configuration request stream. It accepts one head/data packet stream, decodes the 32-bit address in the first-beat head against `CHNL_NUM` base/mask windows and forwards the whole packet to the matching channel. Packets that match no window are drained and logged. It sits between the PCIe BAR request path and the P2P initiator/target/extension engines. It generalises the fixed two-way split at `CFG_BAR_TGT_ADDR_BASE` to N windows, holds the head for the whole packet, and adds unmatched-packet handling.

## Interface
- `CHNL_NUM`, 4: number of output channels, 1..16.
- `HEAD_W`, 128: head width (`P2P_HEAD_W`).
- `DATA_W`, 256: data width (`P2P_DATA_W`).
- `ADDR_LSB`, 32: bit position of the address in the head (address is `head[ADDR_LSB+31:ADDR_LSB]`).
- `BASE_VEC`, 0: `CHNL_NUM*32` bits; channel i base is `BASE_VEC[32*i+:32]`.
- `MASK_VEC`, 0: `CHNL_NUM*32` bits; channel i mask is `MASK_VEC[32*i+:32]`.
- `clk  in  1  clock`; all logic is on the rising edge.
- `rst  in  1  synchronous, active-high reset`.
- `s_valid  in  1` / `s_last  in  1` / `s_head  in  HEAD_W` / `s_data  in  DATA_W` / `s_ready  out  1`: input packet stream. `s_head` is meaningful on the first beat only.
- `m_valid  out  CHNL_NUM` / `m_last  out  CHNL_NUM` / `m_head  out  CHNL_NUM*HEAD_W` / `m_data  out  CHNL_NUM*DATA_W` / `m_ready  in  CHNL_NUM`: output streams. Channel i occupies bit/slice i.
- `busy  out  1`: high while a packet is partially transferred (state FWD or DROP).
- `err_valid  out  1`: one-cycle pulse per dropped packet.
- `err_addr  out  32`: address of the most recently dropped packet.
- `drop_cnt  out  16`: count of dropped packets, saturating.

## Operation
- Stage register: a one-beat holding register (`stg_vld`, `last`, `head`, `data`). The input beat is accepted when `s_valid && s_ready`.
  - `s_ready = !rst && (!stg_vld || stg_pop)`.
  - `stg_pop` is the cycle in which the held beat leaves the register: forwarded with the selected `m_ready` high, or dropped.
- Decode, combinational on `stg_head` while state is IDLE:
  - `hit[i] = ((addr & mask_i) == (base_i & mask_i))`.
  - The lowest hit index wins. If no bit of `hit` is set, the packet is unmatched.
- Routing FSM, states IDLE, FWD, DROP:
  - IDLE, `stg_vld`, hit on channel k: latch `sel=k` and `hold_head=stg_head`, drive channel k.
    - When the beat pops with `last=0`, go to FWD.
    - When it pops with `last=1`, stay in IDLE.
  - IDLE, `stg_vld`, no hit: pop the beat unconditionally in that cycle.
    - Pulse `err_valid` and load `err_addr`.
    - `drop_cnt += 1`, saturating at 0xFFFF.
    - Go to DROP if `last=0`, otherwise stay in IDLE.
  - FWD: present each beat to channel `sel`. Go to IDLE when a beat with `last=1` pops.
  - DROP: pop every beat, one per cycle, with no err pulse and no count change. Go to IDLE when a beat with `last=1` pops.
- Outputs:
  - `m_valid[i] = stg_vld && routing to i && state!=DROP`. Only one bit of `m_valid` is ever high.
  - `m_head[i]` carries the packet's first-beat head on every beat of the packet (`hold_head` in FWD, `stg_head` in IDLE).
  - `m_last[i]` and `m_data[i]` come from the stage register.
  - Non-selected slices are driven to 0.
- A channel whose mask is 0 matches every address. Placing it at the highest index makes it a default route.
- Packet boundaries come from `last` alone; the byte length field is not checked.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `m_head=0`, `m_data=0`, `s_ready=0` while `rst` is high, `busy=0`, `err_valid=0`, `err_addr=0`, `drop_cnt=0`, `stg_vld=0`, state IDLE.
- Reset mid-packet: the partial packet is discarded. The first beat accepted after reset is treated as a head.
- Latency: a beat accepted in cycle t appears on `m_*` in cycle t+1.
- Throughput: one beat per cycle when `m_ready` on the selected channel stays high.
- Drop path: unmatched beats are sunk at one beat per cycle regardless of `m_ready`. `err_valid` is asserted in the cycle the head beat is dropped.
- Handshake rules:
  - Once `m_valid[i]` is high, it stays high and `m_head`/`m_data`/`m_last` stay stable until `m_ready[i]`.
  - A back-pressured channel never stalls a decision already made, and never changes `sel` mid-packet.
- Simultaneous pop and accept: when the stage register pops and a new beat is accepted in the same cycle, the new beat is held next cycle with no bubble. This includes the new packet's head directly after a `last` beat.
- Single-beat packets (`last=1` on the head) complete in IDLE with no state transition.

## Test plan
- Setup for all cases: `CHNL_NUM=4`, masks 0xF0000000.
  - Bases: 0x00000000, 0x10000000, 0x20000000, 0x30000000 on channels 0, 1, 2, 3.
  - `ADDR_LSB=32`.
- 3-beat packet to address 0x20000040, `m_ready` all 1 -> only `m_valid[2]` high for 3 consecutive cycles, starting 1 cycle after the head is accepted; `m_head[2]` identical on all beats; `m_last[2]` on beat 3.
- Packet to address 0x50000000, 4 beats -> no `m_valid`; `err_valid` pulses once; `err_addr`=0x50000000; `drop_cnt`=1; `s_ready` stays high for all 4 beats.
- Back-to-back single-beat packets to 0x00000000 and 0x30000000, then `m_ready[0]` held low for 5 cycles -> `m_valid[0]` stable for 5 cycles with data unchanged, channel 3 receives nothing until channel 0 accepts, no beat is lost.
- Overlapping windows: set `MASK_VEC` for channel 3 to 0 and send to 0x10000000 -> routed to channel 1 (lowest index wins); 0x70000000 routed to channel 3 with `drop_cnt` unchanged.
- `rst` asserted during beat 2 of a 4-beat packet -> all outputs at reset values next cycle; the next accepted beat is decoded as a head; `busy`=0 after reset.
- 65540 unmatched packets -> `drop_cnt` saturates at 0xFFFF; `err_valid` still pulses for each packet.
